// File: rtl/canvas_pkg.sv
// Shared constants and state encoding for the canvas pixel sequencer.
// The canvas address is {x, y}, so a linear count walks y fastest.
package canvas_pkg;

    localparam int unsigned X_BITS       = 7;
    localparam int unsigned Y_BITS       = 6;
    localparam int unsigned LOC_BITS     = X_BITS + Y_BITS;
    localparam logic [LOC_BITS-1:0] LAST_LOC = '1;

    localparam int unsigned CAM_NORMAL_W = 31;
    localparam int unsigned CAM_DIST_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT,
        DONE
    } scan_state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter that times how long view_loc has been held for the ray stage.
// expire is high in the cycle whose closing edge brings the count to zero.
module scan_settle_timer #(
    parameter int unsigned LOAD_VAL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expire
);

    localparam int unsigned CW = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LOAD_VAL);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt <= CW'(1));

endmodule

// File: rtl/canvas_scan.sv
// Pixel sequencer: latches camera parameters per frame, walks every canvas location,
// holds each for the ray settle time, then hands the address downstream via valid/ready.
module canvas_scan
    import canvas_pkg::*;
#(
    parameter int unsigned RAY_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CAM_NORMAL_W-1:0] view_normal_in,
    input  logic [CAM_DIST_W-1:0]   view_dist_in,
    output logic [CAM_NORMAL_W-1:0] view_normal,
    output logic [CAM_DIST_W-1:0]   view_dist,
    output logic [LOC_BITS-1:0]     view_loc,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [LOC_BITS-1:0]     pix_addr,
    output logic                    busy,
    output logic                    frame_done
);

    // With no settle time a new location is already presentable on the next cycle.
    localparam scan_state_t ARM_STATE = (RAY_LATENCY == 0) ? PRESENT : SETTLE;

    scan_state_t             state_q, state_d;
    logic [LOC_BITS-1:0]     loc_d;
    logic [CAM_NORMAL_W-1:0] normal_d;
    logic [CAM_DIST_W-1:0]   dist_d;
    logic                    timer_load, timer_dec, settle_expire;

    scan_settle_timer #(
        .LOAD_VAL (RAY_LATENCY)
    ) u_settle (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .dec    (timer_dec),
        .expire (settle_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            view_loc    <= '0;
            view_normal <= '0;
            view_dist   <= '0;
            pix_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            view_loc    <= loc_d;
            view_normal <= normal_d;
            view_dist   <= dist_d;
            pix_valid   <= (state_d == PRESENT);
            busy        <= (state_d != IDLE);
            frame_done  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d    = state_q;
        loc_d      = view_loc;
        normal_d   = view_normal;
        dist_d     = view_dist;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    normal_d   = view_normal_in;
                    dist_d     = view_dist_in;
                    loc_d      = '0;
                    timer_load = 1'b1;
                    state_d    = ARM_STATE;
                end
            end
            SETTLE: begin
                timer_dec = 1'b1;
                if (settle_expire) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (pix_valid && pix_ready) begin
                    if (view_loc == LAST_LOC) begin
                        state_d = DONE;
                    end else begin
                        loc_d      = view_loc + 1'b1;
                        timer_load = 1'b1;
                        state_d    = ARM_STATE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pix_addr = view_loc;

endmodule

// File: tb/tb_canvas_scan.sv
// Directed bench for canvas_scan: a default-latency instance and a zero-latency instance,
// with a negedge scoreboard tracking every accepted pixel of the selected instance.
module tb_canvas_scan;
    import canvas_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start0, pix_ready, pix_ready0;
    logic [30:0] normal_in;
    logic [7:0]  dist_in;

    logic [30:0] view_normal, view_normal0;
    logic [7:0]  view_dist, view_dist0;
    logic [12:0] view_loc, view_loc0, pix_addr, pix_addr0;
    logic        pix_valid, pix_valid0, busy, busy0, frame_done, frame_done0;

    canvas_scan dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .view_normal_in (normal_in),
        .view_dist_in   (dist_in),
        .view_normal    (view_normal),
        .view_dist      (view_dist),
        .view_loc       (view_loc),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_addr       (pix_addr),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    canvas_scan #(.RAY_LATENCY(0)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .start          (start0),
        .view_normal_in (normal_in),
        .view_dist_in   (dist_in),
        .view_normal    (view_normal0),
        .view_dist      (view_dist0),
        .view_loc       (view_loc0),
        .pix_valid      (pix_valid0),
        .pix_ready      (pix_ready0),
        .pix_addr       (pix_addr0),
        .busy           (busy0),
        .frame_done     (frame_done0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Written only by the main sequence.
    int unsigned frame_id = 0;
    logic        sel = 1'b0;
    logic [30:0] exp_normal = '0;
    logic [7:0]  exp_dist = '0;

    // Written only by the monitor; cleared whenever frame_id moves on.
    int unsigned mon_id = 0;
    int unsigned hs_cnt = 0, uniq = 0, dup = 0, order_err = 0, done_cnt = 0, cam_bad = 0;
    logic [12:0] next_addr = '0, addr64 = '0;
    bit          seen [8192];

    always @(negedge clk) begin
        logic        h, d, b;
        logic [12:0] a;
        logic [30:0] nrm;
        logic [7:0]  dst;
        if (mon_id != frame_id) begin
            mon_id = frame_id;
            hs_cnt = 0; uniq = 0; dup = 0; order_err = 0; done_cnt = 0; cam_bad = 0;
            next_addr = '0; addr64 = '0;
            for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
        end
        h   = sel ? (pix_valid0 && pix_ready0) : (pix_valid && pix_ready);
        a   = sel ? pix_addr0 : pix_addr;
        d   = sel ? frame_done0 : frame_done;
        b   = sel ? busy0 : busy;
        nrm = sel ? view_normal0 : view_normal;
        dst = sel ? view_dist0 : view_dist;
        if (h) begin
            if (seen[a]) dup++;
            else begin
                seen[a] = 1'b1;
                uniq++;
            end
            if (a != next_addr) order_err++;
            next_addr = next_addr + 1'b1;
            if (hs_cnt == 64) addr64 = a;
            hs_cnt++;
        end
        if (d) done_cnt++;
        if (b && (nrm != exp_normal || dst != exp_dist)) cam_bad++;
    end

    typedef struct {
        logic        start;
        logic        ready;
        logic        busy;
        logic        valid;
        logic [12:0] loc;
        logic        done;
    } vec_t;

    vec_t vecs [20];
    int   n;
    int   seq_bad;

    initial begin
        rst = 1'b1; start = 1'b0; start0 = 1'b0; pix_ready = 1'b0; pix_ready0 = 1'b0;
        normal_in = '0; dist_in = '0;
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_loc", view_loc, 0);
        check("rst_addr", pix_addr, 0);
        check("rst_done", frame_done, 0);
        check("rst_normal", view_normal, 0);
        check("rst_dist", view_dist, 0);
        check("rst_busy0", busy0, 0);
        rst = 1'b0;

        // Idle, then start with ready already high, then the first two pixels.
        for (int i = 0; i < 20; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 13'h0, 1'b0};
        for (int i = 11; i < 14; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 13'h0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 13'h0, 1'b0};
        for (int i = 15; i < 19; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 13'h1, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 13'h1, 1'b0};

        normal_in = 31'h12345678; dist_in = 8'd40;
        exp_normal = 31'h12345678; exp_dist = 8'd40;
        frame_id++;
        for (int i = 0; i < 20; i++) begin
            start = vecs[i].start;
            pix_ready = vecs[i].ready;
            step();
            if (i == 10) begin
                normal_in = '0;
                dist_in = '0;
            end
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_valid", i), pix_valid, vecs[i].valid);
            check($sformatf("vec%0d_loc", i), view_loc, vecs[i].loc);
            check($sformatf("vec%0d_addr", i), pix_addr, vecs[i].loc);
            check($sformatf("vec%0d_done", i), frame_done, vecs[i].done);
        end

        // Full frame with ready high and a stray start pulse mid-frame.
        n = 10;
        while (!frame_done && n < 41500) begin
            start = (n == 2000);
            step();
            n++;
        end
        start = 1'b0;
        check("frame_done_cycle", n, 40961);
        check("frame_normal_held", view_normal, 31'h12345678);
        check("frame_dist_held", view_dist, 40);
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_start_busy", busy, 0);
        check("done_start_valid", pix_valid, 0);
        check("done_start_done", frame_done, 0);
        check("done_loc_last", view_loc, 13'h1FFF);
        repeat (3) step();
        check("idle_after_done_busy", busy, 0);
        check("frame_unique", uniq, 8192);
        check("frame_dup", dup, 0);
        check("frame_order", order_err, 0);
        check("pixel64_addr", addr64, 13'h0040);
        check("frame_done_count", done_cnt, 1);
        check("frame_cam_stable", cam_bad, 0);

        // Reset while settling on location 0x100, then restart.
        frame_id++;
        normal_in = 31'h07ABCDEF; dist_in = 8'd9;
        exp_normal = 31'h07ABCDEF; exp_dist = 8'd9;
        pix_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(view_loc == 13'h100 && !pix_valid) && n < 3000) begin
            step();
            n++;
        end
        check("reach_0x100_settle", (view_loc == 13'h100 && !pix_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_loc", view_loc, 0);
        check("midrst_addr", pix_addr, 0);
        check("midrst_valid", pix_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", frame_done, 0);
        check("midrst_normal", view_normal, 0);
        check("midrst_dist", view_dist, 0);
        repeat (5) step();
        check("midrst_stays_idle", busy, 0);
        check("midrst_no_done", done_cnt, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_loc", view_loc, 0);
        n = 0;
        while (!pix_valid && n < 20) begin
            step();
            n++;
        end
        check("restart_settle_len", n, 4);
        check("restart_addr", pix_addr, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pix_ready = 1'b0;

        // Zero-latency instance: one pixel per cycle.
        frame_id++;
        sel = 1'b1;
        normal_in = 31'h0055AA33; dist_in = 8'd200;
        exp_normal = 31'h0055AA33; exp_dist = 8'd200;
        pix_ready0 = 1'b1; start0 = 1'b1;
        step();
        start0 = 1'b0;
        n = 1;
        check("lat0_first_valid", pix_valid0, 1);
        check("lat0_first_addr", pix_addr0, 0);
        seq_bad = 0;
        while (!frame_done0 && n < 8300) begin
            if (!(pix_valid0 && pix_addr0 == 13'(n - 1))) seq_bad++;
            step();
            n++;
        end
        check("lat0_done_cycle", n, 8193);
        check("lat0_seq", seq_bad, 0);
        step();
        check("lat0_idle_busy", busy0, 0);
        check("lat0_unique", uniq, 8192);
        check("lat0_done_count", done_cnt, 1);
        check("lat0_cam_stable", cam_bad, 0);

        // Zero-latency instance with ready withdrawn for 7 cycles at pixel 5.
        frame_id++;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        n = 1;
        while (!(pix_valid0 && pix_addr0 == 13'h5) && n < 50) begin
            step();
            n++;
        end
        check("stall_reach_5", n, 6);
        pix_ready0 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            n++;
            check($sformatf("stall%0d_valid", k), pix_valid0, 1);
            check($sformatf("stall%0d_addr", k), pix_addr0, 13'h5);
            check($sformatf("stall%0d_loc", k), view_loc0, 13'h5);
        end
        pix_ready0 = 1'b1;
        step();
        n++;
        check("stall_release_addr", pix_addr0, 13'h6);
        check("stall_release_valid", pix_valid0, 1);
        while (!frame_done0 && n < 8400) begin
            step();
            n++;
        end
        check("stall_done_cycle", n, 8200);
        step();
        check("stall_unique", uniq, 8192);
        check("stall_dup", dup, 0);
        check("stall_order", order_err, 0);
        check("stall_done_count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
